jtframe_dwnld_sdram: RTL and testbench
======================================

JTFRAME_DWNLD_SDRAM -- requirements
Module: jtframe_dwnld_sdram

Interface
REQ-001 SHALL have parameter HEADER, default 0: number of leading download bytes discarded.
REQ-002 SHALL have parameters BA1_START, BA2_START, BA3_START, defaults 25'h08_0000, 25'h10_0000, 25'h18_0000: post-header byte offsets where banks 1..3 begin.
REQ-003 SHALL have parameter HOLD, default 16: cycles dwnld_busy stays high after all activity ends.
REQ-004 SHALL have ports, clock and reset first:
 clk_rom  in  1  single clock, all logic on rising edge
 rst  in  1  asynchronous, active-high reset
 downloading  in  1  ROM download in progress
 ioctl_addr  in  25  byte address of incoming byte
 ioctl_data  in  8  incoming byte
 ioctl_wr  in  1  one-cycle byte strobe
 prog_addr  out  22  16-bit word address within bank
 prog_data  out  8  byte to write
 prog_mask  out  2  active-low byte enable, {hi,lo}
 prog_bank  out  2  SDRAM bank
 prog_we  out  1  write request, held until accepted
 prog_rdy  in  1  one-cycle acceptance of current write
 dwnld_busy  out  1  download or SDRAM programming pending
 overflow  out  1  sticky: a byte was dropped

Function
REQ-005 SHALL sample ioctl_wr only while downloading=1; strobes with downloading=0 ignored.
REQ-006 SHALL discard bytes with ioctl_addr < HEADER; offset a = ioctl_addr - HEADER for all others.
REQ-007 SHALL select bank: a<BA1_START ->0; a<BA2_START ->1; a<BA3_START ->2; else 3.
REQ-008 SHALL set prog_addr = (a - start_of_selected_bank)>>1, truncated to 22 bits.
REQ-009 SHALL set prog_mask = 2'b10 for even a (low byte), 2'b01 for odd a.
REQ-010 SHALL compute bank/address/mask on push and store {addr,bank,mask,data} in a 4-entry FIFO.
REQ-011 Output FSM SHALL have states IDLE, WRITE, GAP; prog_we=1 only in WRITE.
REQ-012 IDLE: FIFO non-empty -> pop head into output registers, go WRITE next cycle; else stay.
REQ-013 WRITE: hold prog_addr/data/mask/bank stable; prog_rdy=1 -> GAP (prog_we low on next cycle); else stay.
REQ-014 GAP: unconditional -> IDLE; guarantees >=1 low cycle of prog_we between writes; minimum 3 cycles per byte.
REQ-015 Push and pop in the same cycle SHALL both take effect, including when FIFO is full.
REQ-016 Push when full without a pop SHALL drop the byte and set overflow; FIFO contents unchanged.
REQ-017 A rising edge of downloading SHALL flush the FIFO, clear overflow, force FSM to IDLE with prog_we=0.
REQ-018 Hold counter SHALL reload to HOLD while downloading|FIFO non-empty|prog_we, else decrement to 0 and stop.
REQ-019 dwnld_busy SHALL equal downloading | FIFO non-empty | prog_we | (counter!=0), registered-free combinational OR.
REQ-020 prog_rdy outside WRITE SHALL be ignored.

Reset
REQ-021 On rst=1, asynchronously: FSM IDLE, FIFO empty, counter 0, prog_we=0, prog_addr=0, prog_data=0, prog_mask=2'b11, prog_bank=0, overflow=0, dwnld_busy follows downloading only.
REQ-022 rst asserted mid-write SHALL abandon the pending write; no write resumes after release.

Verification
REQ-023 Bytes 8'hA5@0, 8'h5A@1, prog_rdy 2 cycles after each prog_we rise -> writes (addr 0,bank 0,mask 10,A5), (addr 0,bank 0,mask 01,5A).
REQ-024 Byte @25'h08_0003 -> prog_bank=1, prog_addr=1, mask=01; byte @25'h18_0000 -> bank 3, addr 0, mask 10.
REQ-025 HEADER=16, bytes @0..15 then @16 -> only one write, addr 0, bank 0, mask 10.
REQ-026 prog_rdy held 0, 6 strobes -> first popped, 4 queued, 6th dropped, overflow=1; new downloading rise clears it.
REQ-027 downloading falls after last write accepted -> dwnld_busy stays 1 exactly HOLD=16 cycles then 0.
REQ-028 rst pulse while prog_we=1 -> prog_we=0 immediately, FIFO empty, no further write after release.

Source files
------------

// File: rtl/jtframe_dwnld_sdram.sv
// ROM download to SDRAM programming bridge: maps download bytes to bank/word
// address, buffers them in a 4-deep FIFO and issues handshaked byte writes.
module jtframe_dwnld_sdram #(
  parameter int          HEADER    = 0,
  parameter logic [24:0] BA1_START = 25'h08_0000,
  parameter logic [24:0] BA2_START = 25'h10_0000,
  parameter logic [24:0] BA3_START = 25'h18_0000,
  parameter int          HOLD      = 16
) (
  input  logic        clk_rom,
  input  logic        rst,
  input  logic        downloading,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  output logic [21:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic [1:0]  prog_mask,
  output logic [1:0]  prog_bank,
  output logic        prog_we,
  input  logic        prog_rdy,
  output logic        dwnld_busy,
  output logic        overflow
);

  localparam int          CW     = HOLD > 0 ? $clog2(HOLD + 1) : 1;
  localparam logic [CW-1:0] HOLD_V = CW'(HOLD);
  localparam logic [24:0] HDR    = 25'(HEADER);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  typedef struct packed {
    logic [21:0] addr;
    logic [1:0]  bank;
    logic [1:0]  mask;
    logic [7:0]  data;
  } entry_t;

  entry_t        mem [4];
  entry_t        new_e;
  logic [1:0]    wr_ptr, rd_ptr, state;
  logic [2:0]    count;
  logic [CW-1:0] hold_cnt;
  logic          dl_l;
  logic [24:0]   a, base, offs;
  logic          push, pop, do_push, dl_rise, empty, full;

  // Bank decode and in-bank word address for the byte being pushed
  always_comb begin
    a    = ioctl_addr - HDR;
    base = 25'd0;
    new_e.bank = 2'd0;
    if (a >= BA3_START) begin
      base = BA3_START; new_e.bank = 2'd3;
    end else if (a >= BA2_START) begin
      base = BA2_START; new_e.bank = 2'd2;
    end else if (a >= BA1_START) begin
      base = BA1_START; new_e.bank = 2'd1;
    end
    offs       = a - base;
    new_e.addr = offs[22:1];
    new_e.mask = a[0] ? 2'b01 : 2'b10;
    new_e.data = ioctl_data;
  end

  assign dl_rise = downloading & ~dl_l;
  assign empty   = count == 3'd0;
  assign full    = count == 3'd4;
  assign push    = downloading & ioctl_wr & (ioctl_addr >= HDR);
  assign pop     = (state == IDLE) & ~empty & ~dl_rise;
  // A pop frees a slot in the same cycle, so a full FIFO can still accept
  assign do_push = push & (~full | pop) & ~dl_rise;

  always_ff @(posedge clk_rom) begin
    if (do_push) mem[wr_ptr] <= new_e;
  end

  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      dl_l     <= 1'b0;
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      count    <= 3'd0;
      overflow <= 1'b0;
    end else begin
      dl_l <= downloading;
      if (dl_rise) begin
        wr_ptr   <= 2'd0;
        rd_ptr   <= 2'd0;
        count    <= 3'd0;
        overflow <= 1'b0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 2'd1;
        if (pop)     rd_ptr <= rd_ptr + 2'd1;
        count <= count + {2'd0, do_push} - {2'd0, pop};
        if (push & full & ~pop) overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      prog_we   <= 1'b0;
      prog_addr <= 22'd0;
      prog_data <= 8'd0;
      prog_mask <= 2'b11;
      prog_bank <= 2'd0;
    end else if (dl_rise) begin
      state   <= IDLE;
      prog_we <= 1'b0;
    end else begin
      case (state)
        IDLE: if (!empty) begin
          prog_addr <= mem[rd_ptr].addr;
          prog_bank <= mem[rd_ptr].bank;
          prog_mask <= mem[rd_ptr].mask;
          prog_data <= mem[rd_ptr].data;
          prog_we   <= 1'b1;
          state     <= WRITE;
        end
        WRITE: if (prog_rdy) begin
          prog_we <= 1'b0;
          state   <= GAP;
        end
        GAP:     state <= IDLE;
        default: begin
          state   <= IDLE;
          prog_we <= 1'b0;
        end
      endcase
    end
  end

  // Keeps busy asserted for HOLD cycles once everything has gone quiet
  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst)                             hold_cnt <= '0;
    else if (downloading | ~empty | prog_we) hold_cnt <= HOLD_V;
    else if (hold_cnt != '0)             hold_cnt <= hold_cnt - 1'b1;
  end

  assign dwnld_busy = downloading | ~empty | prog_we | (hold_cnt != '0);

endmodule

// File: tb/tb_jtframe_dwnld_sdram.sv
// Scoreboard bench: stimulus queues expected writes from an arithmetic model,
// a negedge monitor pops and compares on every accepted write.
module tb_jtframe_dwnld_sdram;

  typedef struct packed {
    logic [21:0] addr;
    logic [1:0]  bank;
    logic [1:0]  mask;
    logic [7:0]  data;
  } exp_t;

  logic        clk, rst, downloading, ioctl_wr, prog_rdy;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic [21:0] prog_addr, h_addr;
  logic [7:0]  prog_data, h_data;
  logic [1:0]  prog_mask, prog_bank, h_mask, h_bank;
  logic        prog_we, dwnld_busy, overflow, h_we, h_busy, h_ovf;
  logic        h_rdy;

  int   checks = 0, passed = 0, writes = 0;
  exp_t q[$];
  bit   rdy_en = 0, rnd_rdy = 0;
  int   rdy_dly = 1;
  int   h_cnt = 0;
  exp_t h_last;

  jtframe_dwnld_sdram dut (
    .clk_rom(clk), .rst(rst), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
    .prog_bank(prog_bank), .prog_we(prog_we), .prog_rdy(prog_rdy),
    .dwnld_busy(dwnld_busy), .overflow(overflow));

  jtframe_dwnld_sdram #(.HEADER(16)) dut_h (
    .clk_rom(clk), .rst(rst), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
    .prog_addr(h_addr), .prog_data(h_data), .prog_mask(h_mask),
    .prog_bank(h_bank), .prog_we(h_we), .prog_rdy(h_rdy),
    .dwnld_busy(h_busy), .overflow(h_ovf));

  assign h_rdy = h_we;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  // Banks are 512 KiB each; word address is half the in-bank byte offset
  function automatic exp_t model(input int unsigned addr, input logic [7:0] d);
    exp_t m;
    int unsigned bk;
    bk     = addr / 32'h8_0000;
    if (bk > 3) bk = 3;
    m.bank = 2'(bk);
    m.addr = 22'((addr - bk * 32'h8_0000) / 2);
    m.mask = (addr % 2 == 1) ? 2'b01 : 2'b10;
    m.data = d;
    return m;
  endfunction

  // Write acceptor
  initial begin
    int wcnt;
    wcnt = 0;
    prog_rdy = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        prog_rdy = 0; wcnt = 0;
      end else if (prog_rdy) begin
        prog_rdy = 0; wcnt = 0;
        if (rnd_rdy) rdy_dly = $urandom_range(0, 3);
      end else if (rdy_en && prog_we) begin
        if (wcnt >= rdy_dly) prog_rdy = 1;
        else wcnt++;
      end else wcnt = 0;
    end
  end

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && prog_we && prog_rdy) begin
        writes++;
        if (q.size() == 0) chk("unexpected_write", {prog_addr, prog_bank, prog_mask, prog_data}, 64'h0);
        else chk("write", {prog_addr, prog_bank, prog_mask, prog_data}, q.pop_front());
      end
      if (!rst && h_we && h_rdy) begin
        h_cnt++;
        h_last = {h_addr, h_bank, h_mask, h_data};
      end
    end
  end

  task automatic send(input logic [24:0] a, input logic [7:0] d, input bit exp);
    ioctl_addr = a; ioctl_data = d; ioctl_wr = 1;
    if (exp && downloading) q.push_back(model(a, d));
    @(posedge clk); #1;
    ioctl_wr = 0;
  endtask

  task automatic paced(input logic [24:0] a, input logic [7:0] d);
    int n;
    n = 0;
    while (q.size() >= 4 && n < 500) begin @(posedge clk); #1; n++; end
    if (n >= 500) chk("pace_timeout", 64'(q.size()), 64'd0);
    send(a, d, 1);
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || prog_we || h_we) && n < 3000) begin @(posedge clk); #1; n++; end
    if (n >= 3000) chk("drain_timeout", 64'(q.size()), 64'd0);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  initial begin
    int n, w0;
    logic [24:0] ra;
    logic [7:0]  d16;
    rst = 1; downloading = 0; ioctl_wr = 0; ioctl_addr = 0; ioctl_data = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", 64'(prog_we), 64'd0);
    chk("rst_addr", 64'(prog_addr), 64'd0);
    chk("rst_data", 64'(prog_data), 64'd0);
    chk("rst_mask", 64'(prog_mask), 64'd3);
    chk("rst_bank", 64'(prog_bank), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_busy_idle", 64'(dwnld_busy), 64'd0);
    downloading = 1;
    #1 chk("rst_busy_dl", 64'(dwnld_busy), 64'd1);
    @(posedge clk); #1;
    rst = 0;
    repeat (2) begin @(posedge clk); #1; end

    // Basic pair, then bank-boundary bytes
    rdy_en = 1; rdy_dly = 1;
    send(25'h0, 8'hA5, 1);
    repeat (8) begin @(posedge clk); #1; end
    send(25'h1, 8'h5A, 1);
    drain();
    paced(25'h08_0003, 8'h3C);
    paced(25'h18_0000, 8'hC3);
    paced(25'h07_FFFF, 8'h11);
    paced(25'h10_0000, 8'h22);
    drain();
    chk("basic_count", 64'(writes), 64'd6);

    // Header skipping on the HEADER=16 instance
    downloading = 0; @(posedge clk); #1;
    downloading = 1; @(posedge clk); #1;
    h_cnt = 0;
    d16 = 8'($urandom);
    for (int i = 0; i < 16; i++) paced(25'(i), 8'($urandom));
    paced(25'd16, d16);
    drain();
    chk("hdr_count", 64'(h_cnt), 64'd1);
    chk("hdr_write", 64'(h_last), 64'({22'd0, 2'd0, 2'b10, d16}));

    // Randomized traffic with random acceptance latency
    rnd_rdy = 1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0)
        ra = 25'(32'h8_0000 * $urandom_range(1, 3) + $urandom_range(0, 3) - 2);
      else
        ra = 25'($urandom_range(0, 32'h1FF_FFFF));
      paced(ra, 8'($urandom));
    end
    drain();
    chk("rand_ovf", 64'(overflow), 64'd0);
    rnd_rdy = 0; rdy_dly = 1;

    // Overflow: no acceptance, six back-to-back strobes
    rdy_en = 0;
    for (int i = 0; i < 6; i++) send(25'(32'h200 + i), 8'($urandom), i < 5);
    repeat (3) begin @(posedge clk); #1; end
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_we_held", 64'(prog_we), 64'd1);
    rdy_en = 1;
    drain();
    chk("ovf_sticky", 64'(overflow), 64'd1);
    downloading = 0; @(posedge clk); #1;
    w0 = writes;
    send(25'h300, 8'h77, 1);
    repeat (6) begin @(posedge clk); #1; end
    downloading = 1; @(posedge clk); #1;
    chk("ovf_cleared", 64'(overflow), 64'd0);
    repeat (10) begin @(posedge clk); #1; end
    chk("idle_strobe_ignored", 64'(writes - w0), 64'd0);

    // Busy hold after downloading falls
    paced(25'h44, 8'h99);
    drain();
    downloading = 0;
    n = 0;
    @(negedge clk);
    while (dwnld_busy && n < 100) begin n++; @(negedge clk); end
    chk("busy_hold", 64'(n), 64'd16);
    chk("busy_low", 64'(dwnld_busy), 64'd0);

    // Reset in the middle of a write
    @(posedge clk); #1;
    downloading = 1; rdy_en = 0;
    repeat (2) begin @(posedge clk); #1; end
    send(25'h10, 8'h12, 1);
    send(25'h11, 8'h34, 1);
    n = 0;
    while (!prog_we && n < 50) begin @(posedge clk); #1; n++; end
    chk("pre_rst_we", 64'(prog_we), 64'd1);
    rst = 1;
    #1;
    chk("mid_rst_we", 64'(prog_we), 64'd0);
    chk("mid_rst_mask", 64'(prog_mask), 64'd3);
    chk("mid_rst_busy", 64'(dwnld_busy), 64'd1);
    q.delete();
    w0 = writes;
    repeat (2) @(posedge clk);
    #1 rst = 0; rdy_en = 1;
    n = 0;
    for (int i = 0; i < 30; i++) begin @(negedge clk); if (prog_we) n++; end
    chk("post_rst_no_we", 64'(n), 64'd0);
    chk("post_rst_writes", 64'(writes - w0), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
